// File: rtl/adc_param_conditioner_pkg.sv
// Shared definitions for the ADC parameter conditioner.
// States, channel indices and the default scale width.
package adc_param_conditioner_pkg;

    localparam int DIV_BIT_DEFAULT = 9;
    localparam int NUM_CH          = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FILTER  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] CH_FREQ   = 2'd0;
    localparam logic [1:0] CH_HSCALE = 2'd1;
    localparam logic [1:0] CH_SINIT  = 2'd2;
    localparam logic [1:0] CH_FSCALE = 2'd3;

endpackage

// File: rtl/adc_param_conditioner_iir.sv
// One step of the shared first-order IIR plus deadband decision.
// Purely combinational; the caller muxes in one channel per cycle.
module iir_step #(
    parameter int SMOOTH_SHIFT = 3,
    parameter int DEADBAND     = 4
) (
    input  logic [16+SMOOTH_SHIFT-1:0] i_acc,
    input  logic [15:0]                i_x,
    input  logic [15:0]                i_staged,
    input  logic                       i_first,
    output logic [16+SMOOTH_SHIFT-1:0] o_acc,
    output logic [15:0]                o_y,
    output logic                       o_update
);

    localparam int          ACC_W = 16 + SMOOTH_SHIFT;
    localparam logic [15:0] DB    = 16'(DEADBAND);

    logic [ACC_W-1:0] acc_filt;
    logic [15:0]      diff;

    // Filter update (or preload on first frame) and deadband test
    always_comb begin
        // The true result always fits in ACC_W bits, so modular math is exact
        acc_filt = i_acc + {{SMOOTH_SHIFT{1'b0}}, i_x}
                 - (i_acc >> SMOOTH_SHIFT);
        if (i_first) begin
            o_acc = {i_x, {SMOOTH_SHIFT{1'b0}}};
            o_y   = i_x;
        end else begin
            o_acc = acc_filt;
            o_y   = acc_filt[ACC_W-1:SMOOTH_SHIFT];
        end
        diff     = (o_y > i_staged) ? (o_y - i_staged)
                                    : (i_staged - o_y);
        o_update = i_first || (diff > DB);
    end

endmodule

// File: rtl/adc_param_conditioner.sv
// Smooths the four ADC control words and releases them to the
// harmonic engine only on a sample-frame boundary.
module adc_param_conditioner
    import adc_param_conditioner_pkg::*;
#(
    parameter int          DIV_BIT      = DIV_BIT_DEFAULT,
    parameter int          SMOOTH_SHIFT = 3,
    parameter int          DEADBAND     = 4,
    parameter logic [15:0] FREQ_RESET   = 16'd1000
) (
    input  logic               fpga_clock,
    input  logic               reset,
    input  logic [15:0]        i_adc_data0,
    input  logic [15:0]        i_adc_data1,
    input  logic [15:0]        i_adc_data2,
    input  logic [15:0]        i_adc_data3,
    input  logic               i_adc_received,
    input  logic               i_frame_start,
    output logic [15:0]        o_frequency,
    output logic [DIV_BIT-1:0] o_harmonic_scale,
    output logic [DIV_BIT-1:0] o_scale_initial,
    output logic [15:0]        o_freq_scale,
    output logic               o_busy,
    output logic               o_overrun
);

    localparam int          ACC_W     = 16 + SMOOTH_SHIFT;
    localparam logic [15:0] SCALE_MAX = 16'((1 << DIV_BIT) - 1);

    state_t state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic rcv_q, rcv_d;
    logic first_q, first_d;
    logic pending_q, pending_d;
    logic queued_q, queued_d;
    logic overrun_q, overrun_d;

    logic [15:0]      cap_q    [NUM_CH];
    logic [15:0]      cap_d    [NUM_CH];
    logic [15:0]      work_q   [NUM_CH];
    logic [15:0]      work_d   [NUM_CH];
    logic [15:0]      staged_q [NUM_CH];
    logic [15:0]      staged_d [NUM_CH];
    logic [ACC_W-1:0] acc_q    [NUM_CH];
    logic [ACC_W-1:0] acc_d    [NUM_CH];

    logic [15:0]        freq_q, freq_d;
    logic [15:0]        fscale_q, fscale_d;
    logic [DIV_BIT-1:0] hscale_q, hscale_d;
    logic [DIV_BIT-1:0] sinit_q, sinit_d;

    logic             adc_edge;
    logic             busy;
    logic [15:0]      sat1;
    logic [15:0]      sat2;
    logic [ACC_W-1:0] step_acc;
    logic [15:0]      step_y;
    logic             step_update;

    assign adc_edge = i_adc_received & ~rcv_q;
    assign busy     = (state_q != ST_IDLE);

    assign sat1 = (i_adc_data1 > SCALE_MAX) ? SCALE_MAX : i_adc_data1;
    assign sat2 = (i_adc_data2 > SCALE_MAX) ? SCALE_MAX : i_adc_data2;

    iir_step #(
        .SMOOTH_SHIFT (SMOOTH_SHIFT),
        .DEADBAND     (DEADBAND)
    ) u_iir (
        .i_acc    (acc_q[ch_q]),
        .i_x      (cap_q[ch_q]),
        .i_staged (staged_q[ch_q]),
        .i_first  (first_q),
        .o_acc    (step_acc),
        .o_y      (step_y),
        .o_update (step_update)
    );

    // Next-state, datapath and output-transfer logic
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rcv_d     = i_adc_received;
        first_d   = first_q;
        pending_d = pending_q;
        queued_d  = queued_q;
        overrun_d = overrun_q;
        freq_d    = freq_q;
        fscale_d  = fscale_q;
        hscale_d  = hscale_q;
        sinit_d   = sinit_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cap_d[i]    = cap_q[i];
            work_d[i]   = work_q[i];
            staged_d[i] = staged_q[i];
            acc_d[i]    = acc_q[i];
        end

        // Frame boundary: publish the staged set atomically
        if (i_frame_start && pending_q) begin
            freq_d    = staged_q[CH_FREQ];
            hscale_d  = staged_q[CH_HSCALE][DIV_BIT-1:0];
            sinit_d   = staged_q[CH_SINIT][DIV_BIT-1:0];
            fscale_d  = staged_q[CH_FSCALE];
            pending_d = 1'b0;
        end

        // One frame may wait behind the active one; more are lost
        if (busy && adc_edge) begin
            if (queued_q) begin
                overrun_d = 1'b1;
            end else begin
                queued_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (adc_edge || queued_q) begin
                    state_d  = ST_CAPTURE;
                    queued_d = queued_q & adc_edge;
                end
            end
            ST_CAPTURE: begin
                cap_d[CH_FREQ]   = i_adc_data0;
                cap_d[CH_HSCALE] = sat1;
                cap_d[CH_SINIT]  = sat2;
                cap_d[CH_FSCALE] = i_adc_data3;
                ch_d             = CH_FREQ;
                state_d          = ST_FILTER;
            end
            ST_FILTER: begin
                acc_d[ch_q]  = step_acc;
                work_d[ch_q] = step_update ? step_y : staged_q[ch_q];
                ch_d         = ch_q + 2'd1;
                if (ch_q == CH_FSCALE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    staged_d[i] = work_q[i];
                end
                pending_d = 1'b1;
                first_d   = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ch_q      <= CH_FREQ;
            rcv_q     <= 1'b0;
            first_q   <= 1'b1;
            pending_q <= 1'b0;
            queued_q  <= 1'b0;
            overrun_q <= 1'b0;
            freq_q    <= FREQ_RESET;
            fscale_q  <= 16'd0;
            hscale_q  <= '0;
            sinit_q   <= {DIV_BIT{1'b1}};
            for (int i = 0; i < NUM_CH; i++) begin
                cap_q[i] <= 16'd0;
                acc_q[i] <= '0;
            end
            staged_q[CH_FREQ]   <= FREQ_RESET;
            staged_q[CH_HSCALE] <= 16'd0;
            staged_q[CH_SINIT]  <= SCALE_MAX;
            staged_q[CH_FSCALE] <= 16'd0;
            work_q[CH_FREQ]     <= FREQ_RESET;
            work_q[CH_HSCALE]   <= 16'd0;
            work_q[CH_SINIT]    <= SCALE_MAX;
            work_q[CH_FSCALE]   <= 16'd0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            rcv_q     <= rcv_d;
            first_q   <= first_d;
            pending_q <= pending_d;
            queued_q  <= queued_d;
            overrun_q <= overrun_d;
            freq_q    <= freq_d;
            fscale_q  <= fscale_d;
            hscale_q  <= hscale_d;
            sinit_q   <= sinit_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cap_q[i]    <= cap_d[i];
                acc_q[i]    <= acc_d[i];
                staged_q[i] <= staged_d[i];
                work_q[i]   <= work_d[i];
            end
        end
    end

    assign o_frequency      = freq_q;
    assign o_harmonic_scale = hscale_q;
    assign o_scale_initial  = sinit_q;
    assign o_freq_scale     = fscale_q;
    assign o_busy           = busy;
    assign o_overrun        = overrun_q;

endmodule

// File: tb/tb_adc_param_conditioner.sv
// Directed bench for adc_param_conditioner.
// Expected values are hand-computed from the filter equations.
module tb_adc_param_conditioner;

    logic        fpga_clock = 1'b0;
    logic        reset;
    logic [15:0] i_adc_data0;
    logic [15:0] i_adc_data1;
    logic [15:0] i_adc_data2;
    logic [15:0] i_adc_data3;
    logic        i_adc_received;
    logic        i_frame_start;
    logic [15:0] o_frequency;
    logic [8:0]  o_harmonic_scale;
    logic [8:0]  o_scale_initial;
    logic [15:0] o_freq_scale;
    logic        o_busy;
    logic        o_overrun;

    int checks   = 0;
    int failures = 0;

    adc_param_conditioner dut (
        .fpga_clock       (fpga_clock),
        .reset            (reset),
        .i_adc_data0      (i_adc_data0),
        .i_adc_data1      (i_adc_data1),
        .i_adc_data2      (i_adc_data2),
        .i_adc_data3      (i_adc_data3),
        .i_adc_received   (i_adc_received),
        .i_frame_start    (i_frame_start),
        .o_frequency      (o_frequency),
        .o_harmonic_scale (o_harmonic_scale),
        .o_scale_initial  (o_scale_initial),
        .o_freq_scale     (o_freq_scale),
        .o_busy           (o_busy),
        .o_overrun        (o_overrun)
    );

    always #5 fpga_clock = ~fpga_clock;

    task automatic tick();
        @(posedge fpga_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int f, input int h,
                           input int s, input int fs);
        chk({tag, "_freq"},   32'(o_frequency),      f);
        chk({tag, "_hscale"}, 32'(o_harmonic_scale), h);
        chk({tag, "_sinit"},  32'(o_scale_initial),  s);
        chk({tag, "_fscale"}, 32'(o_freq_scale),     fs);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    task automatic adc_frame(input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3,
                             input bit pulse_done);
        int n;
        i_adc_data0    = d0;
        i_adc_data1    = d1;
        i_adc_data2    = d2;
        i_adc_data3    = d3;
        i_adc_received = 1'b1;
        tick();
        i_adc_received = 1'b0;
        n = 0;
        while (o_busy && n < 20) begin
            n++;
            if (pulse_done && n == 6) i_frame_start = 1'b1;
            tick();
            i_frame_start = 1'b0;
        end
        chk("busy_cycles", n, 6);
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        i_adc_data0    = '0;
        i_adc_data1    = '0;
        i_adc_data2    = '0;
        i_adc_data3    = '0;
        i_adc_received = 1'b0;
        i_frame_start  = 1'b0;
        do_reset();

        chk_out("reset", 1000, 0, 511, 0);
        chk("reset_busy",    32'(o_busy),    0);
        chk("reset_overrun", 32'(o_overrun), 0);

        repeat (10) begin
            pulse();
            tick();
        end
        chk_out("idle_pulses", 1000, 0, 511, 0);
        chk("idle_busy", 32'(o_busy), 0);

        // First frame: preload and saturation
        adc_frame(16'd2000, 16'h0400, 16'hFFFF, 16'd300, 1'b0);
        tick();
        chk_out("pre_pulse", 1000, 0, 511, 0);
        pulse();
        chk_out("first", 2000, 511, 511, 300);

        // 2800 twice; second frame gets a pulse in its DONE cycle
        adc_frame(16'd2800, 16'h0400, 16'hFFFF, 16'd300, 1'b0);
        adc_frame(16'd2800, 16'h0400, 16'hFFFF, 16'd300, 1'b1);
        chk_out("done_pulse", 2100, 511, 511, 300);
        pulse();
        chk_out("second", 2187, 511, 511, 300);
        pulse();
        chk("no_pending_hold", 32'(o_frequency), 2187);

        // Deadband from a settled 2000
        do_reset();
        adc_frame(16'd2000, 16'd0, 16'd0, 16'd0, 1'b0);
        pulse();
        chk_out("settle", 2000, 0, 0, 0);
        adc_frame(16'd2030, 16'd0, 16'd0, 16'd0, 1'b0);
        pulse();
        chk("deadband_hold", 32'(o_frequency), 2000);
        adc_frame(16'd2040, 16'd0, 16'd0, 16'd0, 1'b0);
        pulse();
        chk("deadband_follow", 32'(o_frequency), 2008);

        do_reset();
        adc_frame(16'd2000, 16'd0, 16'd0, 16'd0, 1'b0);
        pulse();
        adc_frame(16'd2040, 16'd0, 16'd0, 16'd0, 1'b0);
        pulse();
        chk("deadband_pass", 32'(o_frequency), 2005);

        // Three edges two cycles apart: queue one, drop one
        do_reset();
        i_adc_data0    = 16'd3000;
        i_adc_data1    = 16'd0;
        i_adc_data2    = 16'd0;
        i_adc_data3    = 16'd0;
        i_adc_received = 1'b1;
        tick();
        i_adc_received = 1'b0;
        tick();
        i_adc_received = 1'b1;
        tick();
        i_adc_received = 1'b0;
        i_adc_data0    = 16'd3400;
        tick();
        i_adc_received = 1'b1;
        tick();
        i_adc_received = 1'b0;
        chk("overrun_set", 32'(o_overrun), 1);
        tick();
        tick();
        chk("gap_idle", 32'(o_busy), 0);
        tick();
        chk("queued_start", 32'(o_busy), 1);
        n = 0;
        while (o_busy && n < 20) begin
            n++;
            tick();
        end
        chk("queued_cycles", n, 6);
        tick();
        tick();
        chk("third_dropped", 32'(o_busy), 0);
        pulse();
        chk("queued_value", 32'(o_frequency), 3050);
        chk("overrun_sticky", 32'(o_overrun), 1);

        // Reset in the middle of FILTER
        i_adc_data0    = 16'd100;
        i_adc_received = 1'b1;
        tick();
        i_adc_received = 1'b0;
        tick();
        tick();
        chk("mid_filter_busy", 32'(o_busy), 1);
        reset = 1'b1;
        tick();
        chk_out("mid_reset", 1000, 0, 511, 0);
        chk("mid_reset_busy",    32'(o_busy),    0);
        chk("mid_reset_overrun", 32'(o_overrun), 0);
        reset = 1'b0;
        adc_frame(16'd2500, 16'd0, 16'd0, 16'd0, 1'b0);
        pulse();
        chk("repreload", 32'(o_frequency), 2500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
